// File: rtl/song_pkg.sv
// Shared encodings, note codes and the fixed song table for song_sequencer.
// Table entry layout: {last, len[2:0], key[3:0]}.
package song_pkg;

    localparam int unsigned SONG_SLOTS  = 32;
    localparam int unsigned NOTE_W      = 5;
    localparam int unsigned KEY_W       = 4;
    localparam int unsigned LEN_W       = 3;
    localparam int unsigned ENTRY_W     = 8;
    localparam int unsigned LAST_BIT    = 7;
    localparam int unsigned LEN_MSB     = 6;
    localparam int unsigned LEN_LSB     = 4;
    localparam int unsigned KEY_MSB     = 3;
    localparam int unsigned TABLE_SONGS = 4;
    localparam int unsigned TABLE_DEPTH = TABLE_SONGS * SONG_SLOTS;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SOUND  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_PAUSED = 3'd4;

    // Diatonic note codes, C4 through C6.
    localparam logic [KEY_W-1:0] C4 = 4'd0;
    localparam logic [KEY_W-1:0] D4 = 4'd1;
    localparam logic [KEY_W-1:0] E4 = 4'd2;
    localparam logic [KEY_W-1:0] F4 = 4'd3;
    localparam logic [KEY_W-1:0] G4 = 4'd4;
    localparam logic [KEY_W-1:0] A4 = 4'd5;
    localparam logic [KEY_W-1:0] B4 = 4'd6;
    localparam logic [KEY_W-1:0] C5 = 4'd7;
    localparam logic [KEY_W-1:0] D5 = 4'd8;
    localparam logic [KEY_W-1:0] E5 = 4'd9;
    localparam logic [KEY_W-1:0] F5 = 4'd10;
    localparam logic [KEY_W-1:0] G5 = 4'd11;
    localparam logic [KEY_W-1:0] A5 = 4'd12;
    localparam logic [KEY_W-1:0] B5 = 4'd13;
    localparam logic [KEY_W-1:0] C6 = 4'd14;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic             last,
                                                    input logic [LEN_W-1:0] len,
                                                    input logic [KEY_W-1:0] key);
        return {last, len, key};
    endfunction

    // Song s occupies entries s*32 .. s*32+31; unused slots are zero.
    localparam logic [ENTRY_W-1:0] SONG_TABLE [TABLE_DEPTH] = '{
        0:       mk_entry(1'b0, 3'd2, C4),
        1:       mk_entry(1'b1, 3'd1, E4),
        32:      mk_entry(1'b0, 3'd1, E4),
        33:      mk_entry(1'b0, 3'd1, D4),
        34:      mk_entry(1'b1, 3'd2, C4),
        64:      mk_entry(1'b0, 3'd2, G4),
        65:      mk_entry(1'b0, 3'd2, A4),
        66:      mk_entry(1'b0, 3'd1, G4),
        67:      mk_entry(1'b1, 3'd0, C5),
        96:      mk_entry(1'b0, 3'd1, C5),
        97:      mk_entry(1'b0, 3'd1, B4),
        98:      mk_entry(1'b0, 3'd1, A4),
        99:      mk_entry(1'b1, 3'd3, G4),
        default: '0
    };

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM, one cycle latency, contents from song_pkg.
module song_rom
    import song_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic               clk_i,
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [ENTRY_W-1:0] data_o
);

    localparam int unsigned TBL_IDX_W = $clog2(TABLE_DEPTH);

    logic [ENTRY_W-1:0] data_q;

    // Songs beyond the stored table alias back onto it.
    always_ff @(posedge clk_i) begin
        data_q <= SONG_TABLE[TBL_IDX_W'(addr_i)];
    end

    assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Song playback controller with pause/stop/next and live-key override.
// Optional `SONG_LOOP_EN: restart the same song after its last note instead of idling.
module song_sequencer
    import song_pkg::*;
#(
    parameter  int unsigned NUM_SONGS   = 4,
    parameter  int unsigned UNIT_CYCLES = 25_000_000,
    parameter  int unsigned GAP_CYCLES  = 5_000_000,
    localparam int unsigned SONG_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              play_i,
    input  logic              pause_i,
    input  logic              stop_i,
    input  logic              next_i,
    input  logic              live_on_i,
    input  logic [KEY_W-1:0]  live_key_i,
    output logic [KEY_W-1:0]  key_o,
    output logic              key_on_o,
    output logic              busy_o,
    output logic [SONG_W-1:0] song_idx_o,
    output logic [NOTE_W-1:0] note_idx_o
);

    localparam int unsigned       CNT_W    = $clog2(7 * UNIT_CYCLES);
    localparam int unsigned       ADDR_W   = SONG_W + NOTE_W;
    localparam logic [CNT_W-1:0]  UNIT_C   = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_C    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);
`ifdef SONG_LOOP_EN
    localparam logic [2:0]        SONG_END_ST = ST_LOAD;
`else
    localparam logic [2:0]        SONG_END_ST = ST_IDLE;
`endif

    logic [2:0]         state_q, state_d, resume_q, resume_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [CNT_W-1:0]   dur_q, dur_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               last_q, last_d;
    logic [KEY_W-1:0]   key_seq_q, key_seq_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_on_q, key_on_d;
    logic               busy_q, busy_d;

    logic [ENTRY_W-1:0] rom_data;
    logic [LEN_W-1:0]   rom_len;
    logic [CNT_W-1:0]   note_cycles, sound_end, gap_end;
    logic [2:0]         seq_state;
    logic [NOTE_W-1:0]  seq_note;
    logic [CNT_W-1:0]   seq_dur;
    logic [SONG_W-1:0]  next_song;
    logic               can_pause;

    // Addressed by next-state indices so the entry is ready during LOAD.
    song_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk_i  (clk_i),
        .addr_i ({song_d, note_d}),
        .data_o (rom_data)
    );

    assign note_cycles = CNT_W'(len_q) * UNIT_C;
    assign sound_end   = note_cycles - GAP_C - ONE_C;
    assign gap_end     = note_cycles - ONE_C;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            resume_q  <= ST_IDLE;
            song_q    <= '0;
            note_q    <= '0;
            dur_q     <= '0;
            len_q     <= LEN_W'(1);
            last_q    <= 1'b0;
            key_seq_q <= '0;
            key_q     <= '0;
            key_on_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            song_q    <= song_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            len_q     <= len_d;
            last_q    <= last_d;
            key_seq_q <= key_seq_d;
            key_q     <= key_d;
            key_on_q  <= key_on_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        song_d    = song_q;
        note_d    = note_q;
        dur_d     = dur_q;
        len_d     = len_q;
        last_d    = last_q;
        key_seq_d = key_seq_q;
        seq_state = state_q;
        seq_note  = note_q;
        seq_dur   = dur_q;
        next_song = (song_q == SONG_MAX) ? '0 : song_q + SONG_W'(1);
        rom_len   = rom_data[LEN_MSB:LEN_LSB];

        // Uninterrupted progression through the song.
        case (state_q)
            ST_LOAD: begin
                seq_state = ST_SOUND;
                seq_dur   = '0;
            end
            ST_SOUND: begin
                seq_dur = dur_q + ONE_C;
                if (dur_q == sound_end) seq_state = ST_GAP;
            end
            ST_GAP: begin
                if (dur_q == gap_end) begin
                    seq_dur = '0;
                    if (last_q) begin
                        seq_note  = '0;
                        seq_state = SONG_END_ST;
                    end else begin
                        seq_note  = note_q + NOTE_W'(1);
                        seq_state = ST_LOAD;
                    end
                end else begin
                    seq_dur = dur_q + ONE_C;
                end
            end
            default: ;
        endcase

        can_pause = ((state_q == ST_LOAD) || (state_q == ST_SOUND) || (state_q == ST_GAP))
                    && (seq_state != ST_IDLE);

        // Commands in priority order; a paused LOAD re-reads its entry on resume.
        if (stop_i) begin
            state_d = ST_IDLE;
            note_d  = '0;
            dur_d   = '0;
        end else if (next_i) begin
            song_d = next_song;
            if (state_q != ST_IDLE) begin
                state_d = ST_LOAD;
                note_d  = '0;
                dur_d   = '0;
            end
        end else if (pause_i && can_pause) begin
            state_d  = ST_PAUSED;
            resume_d = (state_q == ST_LOAD) ? ST_LOAD : seq_state;
            note_d   = seq_note;
            dur_d    = seq_dur;
        end else if (play_i && (state_q == ST_IDLE)) begin
            state_d = ST_LOAD;
            note_d  = '0;
            dur_d   = '0;
        end else if (play_i && (state_q == ST_PAUSED)) begin
            state_d = resume_q;
        end else begin
            state_d = seq_state;
            note_d  = seq_note;
            dur_d   = seq_dur;
            if (state_q == ST_LOAD) begin
                key_seq_d = rom_data[KEY_MSB:0];
                len_d     = (rom_len == '0) ? LEN_W'(1) : rom_len;
                last_d    = rom_data[LAST_BIT];
            end
        end

        key_on_d = live_on_i || (state_d == ST_SOUND);
        key_d    = live_on_i ? live_key_i : key_seq_d;
        busy_d   = (state_d != ST_IDLE);
    end

    assign key_o      = key_q;
    assign key_on_o   = key_on_q;
    assign busy_o     = busy_q;
    assign song_idx_o = song_q;
    assign note_idx_o = note_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: expectations are queued per clock edge and
// checked by a monitor sampling 1 time unit after each rising edge.
module tb_song_sequencer;

    localparam int unsigned NUM_SONGS = 4;
    localparam int K_KEYON = 0;
    localparam int K_KEY   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_SONG  = 3;
    localparam int K_NOTE  = 4;

    typedef struct {
        int    at;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       play, pause, stop, next;
    logic       live_on;
    logic [3:0] live_key;
    logic [3:0] key;
    logic       key_on;
    logic       busy;
    logic [1:0] song_idx;
    logic [4:0] note_idx;

    exp_t       sb[$];
    exp_t       cur;
    logic [7:0] obs;
    int         edge_n = 0;
    int         checks = 0;
    int         errors = 0;

    song_sequencer #(
        .NUM_SONGS   (NUM_SONGS),
        .UNIT_CYCLES (10),
        .GAP_CYCLES  (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .play_i     (play),
        .pause_i    (pause),
        .stop_i     (stop),
        .next_i     (next),
        .live_on_i  (live_on),
        .live_key_i (live_key),
        .key_o      (key),
        .key_on_o   (key_on),
        .busy_o     (busy),
        .song_idx_o (song_idx),
        .note_idx_o (note_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_KEYON: return 8'(key_on);
            K_KEY:   return 8'(key);
            K_BUSY:  return 8'(busy);
            K_SONG:  return 8'(song_idx);
            default: return 8'(note_idx);
        endcase
    endfunction

    // Insert keeping the queue ordered by edge number.
    task automatic expect_at(input int at, input int kind, input int val, input string tag);
        exp_t e;
        int   i;
        e.at   = at;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, e);
    endtask

    task automatic expect_span(input int a, input int b, input int kind, input int val,
                               input string tag);
        for (int t = a; t <= b; t++) expect_at(t, kind, val, tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle command pulse; sampled at the rising edge edge_n+1.
    task automatic cmd(input logic p, input logic ps, input logic s, input logic n);
        play  = p;
        pause = ps;
        stop  = s;
        next  = n;
        @(negedge clk);
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        next  = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        edge_n = edge_n + 1;
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            cur = sb.pop_front();
            checks++;
            obs = observe(cur.kind);
            if (cur.at < edge_n) begin
                errors++;
                $display("FAIL %s: sample for edge %0d was missed", cur.tag, cur.at);
            end else begin
                assert (obs === 8'(cur.val)) else begin
                    errors++;
                    $error("FAIL %s @edge %0d: observed %0d expected %0d",
                           cur.tag, edge_n, obs, cur.val);
                end
            end
        end
    end

    initial begin
        int b, p, w, l, r;
        rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; next = 1'b0;
        live_on = 1'b0; live_key = 4'd0;
        step(3);
        rst = 1'b0;

        // Reset state
        b = edge_n;
        expect_at(b + 1, K_KEYON, 0, "rst_keyon");
        expect_at(b + 1, K_KEY,   0, "rst_key");
        expect_at(b + 1, K_BUSY,  0, "rst_busy");
        expect_at(b + 1, K_SONG,  0, "rst_song");
        expect_at(b + 1, K_NOTE,  0, "rst_note");
        step(1);

        // Basic playback of song 0
        b = edge_n;
        expect_at(b + 1, K_BUSY, 1, "load_busy");
        expect_at(b + 1, K_KEYON, 0, "load_off");
        expect_span(b + 2, b + 19, K_KEYON, 1, "n0_on");
        expect_at(b + 2, K_KEY, 0, "n0_key");
        expect_span(b + 20, b + 21, K_KEYON, 0, "n0_gap");
        expect_at(b + 21, K_BUSY, 1, "gap_busy");
        expect_at(b + 22, K_KEYON, 0, "load1_off");
        expect_at(b + 22, K_NOTE, 1, "load1_note");
        expect_span(b + 23, b + 30, K_KEYON, 1, "n1_on");
        expect_at(b + 23, K_KEY, 2, "n1_key");
        expect_span(b + 31, b + 32, K_KEYON, 0, "n1_gap");
        expect_at(b + 33, K_NOTE, 0, "end_note");
`ifdef SONG_LOOP_EN
        expect_at(b + 33, K_BUSY, 1, "loop_busy");
        expect_at(b + 34, K_KEYON, 1, "loop_keyon");
        expect_at(b + 34, K_KEY, 0, "loop_key");
`else
        expect_at(b + 33, K_BUSY, 0, "end_busy");
        expect_at(b + 33, K_KEYON, 0, "end_keyon");
        expect_at(b + 36, K_BUSY, 0, "end_idle");
`endif
        expect_at(b + 37, K_BUSY, 0, "stop_busy");
        expect_at(b + 37, K_KEYON, 0, "stop_keyon");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(35);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        step(2);

        // Pause 5 cycles into note 0, resume 50 cycles later
        p = edge_n;
        expect_span(p + 2, p + 6, K_KEYON, 1, "pre_pause_on");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(5);
        expect_at(p + 7, K_KEYON, 0, "pause_off");
        expect_at(p + 7, K_BUSY, 1, "pause_busy");
        expect_at(p + 7, K_KEY, 0, "pause_key");
        expect_at(p + 30, K_KEYON, 0, "paused_mid");
        expect_at(p + 56, K_KEYON, 0, "paused_end");
        expect_at(p + 56, K_NOTE, 0, "paused_note");
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        step(49);
        expect_span(p + 57, p + 69, K_KEYON, 1, "resume_on");
        expect_span(p + 70, p + 71, K_KEYON, 0, "resume_gap");
        expect_at(p + 72, K_NOTE, 1, "resume_next_note");
        expect_at(p + 72, K_BUSY, 1, "resume_busy");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(17);

        // stop and next together: stop wins
        expect_at(p + 75, K_KEYON, 0, "prio_keyon");
        expect_at(p + 75, K_BUSY, 0, "prio_busy");
        expect_at(p + 75, K_SONG, 0, "prio_song");
        expect_at(p + 75, K_NOTE, 0, "prio_note");
        cmd(1'b0, 1'b0, 1'b1, 1'b1);

        // next in IDLE only advances the song
        for (int s = 1; s <= 3; s++) begin
            expect_at(edge_n + 1, K_SONG, s, "idle_next_song");
            expect_at(edge_n + 1, K_BUSY, 0, "idle_next_busy");
            cmd(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Play song 3, then next wraps to song 0
        w = edge_n;
        expect_at(w + 1, K_SONG, 3, "s3_song");
        expect_at(w + 2, K_KEYON, 1, "s3_keyon");
        expect_at(w + 2, K_KEY, 7, "s3_key");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        expect_at(w + 4, K_SONG, 0, "wrap_song");
        expect_at(w + 4, K_NOTE, 0, "wrap_note");
        expect_at(w + 4, K_BUSY, 1, "wrap_busy");
        expect_at(w + 4, K_KEYON, 0, "wrap_load");
        expect_at(w + 5, K_KEYON, 1, "wrap_keyon");
        expect_at(w + 5, K_KEY, 0, "wrap_key");
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        step(2);
        expect_at(w + 7, K_KEYON, 0, "wrap_stop");
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        step(1);

        // Live key during GAP, timing underneath unchanged
        l = edge_n;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(19);
        expect_at(l + 21, K_KEY, 9, "live_key");
        expect_at(l + 21, K_KEYON, 1, "live_keyon");
        expect_at(l + 21, K_NOTE, 0, "live_note");
        expect_at(l + 22, K_KEYON, 0, "live_rel_off");
        expect_at(l + 22, K_KEY, 0, "live_rel_key");
        expect_at(l + 22, K_NOTE, 1, "live_rel_note");
        expect_span(l + 23, l + 30, K_KEYON, 1, "live_n1_on");
        expect_at(l + 23, K_KEY, 2, "live_n1_key");
        expect_at(l + 31, K_KEYON, 0, "live_n1_gap");
        live_on  = 1'b1;
        live_key = 4'd9;
        @(negedge clk);
        live_on  = 1'b0;
        live_key = 4'd0;
        step(12);
        expect_at(l + 34, K_BUSY, 0, "live_stop");
        cmd(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a note of song 1
        r = edge_n;
        expect_at(r + 1, K_SONG, 1, "r_song_sel");
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(r + 3, K_KEYON, 1, "r_keyon");
        expect_at(r + 3, K_KEY, 2, "r_key");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        expect_at(r + 5, K_KEYON, 0, "midrst_keyon");
        expect_at(r + 5, K_KEY, 0, "midrst_key");
        expect_at(r + 5, K_BUSY, 0, "midrst_busy");
        expect_at(r + 5, K_SONG, 0, "midrst_song");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(3);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Playback controller for the piano's single note output. Steps through a fixed song table of {key, length} entries, times each note against a tempo unit, and inserts a short articulation gap between notes. It accepts play/pause/stop/next commands and gives a live keyboard press priority over playback. Its `key`/`key_on` drive the tone generator directly.

## Interface
- `NUM_SONGS`, 4: songs in the table; each song owns 32 consecutive entries starting at `s*32`.
- `UNIT_CYCLES`, 25_000_000: clock cycles per length unit (one eighth note).
- `GAP_CYCLES`, 5_000_000: silent cycles at the end of every note. Must satisfy `0 < GAP_CYCLES < UNIT_CYCLES`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `play` in 1: single-cycle pulse; start from IDLE or resume from PAUSED.
- `pause` in 1: single-cycle pulse; freeze playback.
- `stop` in 1: single-cycle pulse; abort and return to IDLE.
- `next` in 1: single-cycle pulse; advance to the next song, note 0.
- `live_on` in 1: live key held.
- `live_key` in 4: live key code, 0..14.
- `key` out 4: note code to the tone generator.
- `key_on` out 1: tone enable.
- `busy` out 1: high in LOAD/SOUND/GAP/PAUSED.
- `song_idx` out $clog2(NUM_SONGS): current song.
- `note_idx` out 5: current entry within the song.

## Operation
- **Table entry** (8 bits): {last[7], len[6:4], key[3:0]}.
  - `len` is 1..7 units; `len == 0` is treated as 1.
  - `last` marks the final note of the song.
  - The table is a synchronous-read ROM with 1-cycle read latency.
- **States:** IDLE, LOAD, SOUND, GAP, PAUSED.
  - **IDLE:** `play` → LOAD with the current `song_idx`, `note_idx = 0`.
  - **LOAD:** one cycle for the ROM read. Latch key/len, clear `dur_cnt`, → SOUND.
  - **SOUND:** `dur_cnt` increments each cycle. At `dur_cnt == len*UNIT_CYCLES - GAP_CYCLES - 1` → GAP.
  - **GAP:** counts to `len*UNIT_CYCLES - 1`. Then:
    - If `last == 0`: `note_idx + 1`, → LOAD.
    - If `last == 1`: `note_idx = 0`, song ends (see Configuration).
  - **PAUSED:** `dur_cnt` and indices are held. `play` returns to the state that was paused (SOUND or GAP); the same count is resumed.
- **Commands** are honoured only when the state permits; otherwise they are ignored.
  - Same-cycle priority: stop > next > pause > play.
  - `stop` from any state → IDLE; `note_idx = 0`; `song_idx` is kept.
  - `next` from any non-IDLE state → LOAD with `song_idx + 1`, wrapping `NUM_SONGS-1` → 0, and `note_idx = 0`.
  - `next` in IDLE only advances `song_idx`.
- **Sequencer output:**
  - `key_on_seq` = state is SOUND.
  - `key_seq` = latched key, held through GAP and PAUSED.
- **Live override:**
  - While `live_on`: `key = live_key`, `key_on = 1`.
  - The sequencer keeps running underneath, so playback timing is not stretched.
  - When `live_on` falls, the outputs revert to the sequencer values on the next registered update.
- **Duration counter width:** `$clog2(7*UNIT_CYCLES)`. Products are computed at that width; there is no overflow at `len = 7`.

## Timing
- **Reset values:** state IDLE; `key = 0`, `key_on = 0`, `busy = 0`, `song_idx = 0`, `note_idx = 0`, `dur_cnt = 0`.
- **`rst` mid-note:** `key_on` is low on the first cycle after reset.
- **All outputs are registered.**
- **Start latency:** `play` sampled at cycle N → LOAD at N+1 → `key`/`key_on` valid at N+2.
- **Note period:** exactly `len*UNIT_CYCLES` cycles in SOUND+GAP, plus 1 LOAD cycle.
  - `key_on` is high for `len*UNIT_CYCLES - GAP_CYCLES` cycles.
- **Pause/stop latency:** `pause` or `stop` at cycle N → `key_on` low at N+1 (unless `live_on`).
- **Live latency:** `live_on` rise at N → `key = live_key`, `key_on = 1` at N+1.
- **Command during LOAD:** acts on the next cycle's state; the ROM data for that LOAD is discarded.

## Configuration
- `SONG_LOOP_EN` defined: after the `last` note, → LOAD of the same song, note 0. `busy` stays high.
- `SONG_LOOP_EN` undefined: after the `last` note, → IDLE with `busy = 0`. `song_idx` is unchanged, so `play` replays the same song.

## Structure
- **Package `song_pkg`:**
  - state enum;
  - entry field positions (`LAST_BIT`, `LEN_MSB`, `LEN_LSB`, `KEY_MSB`);
  - `SONG_SLOTS = 32`;
  - note code constants (C4 = 0 … C6 = 14);
  - the song table contents as a constant array.
- **Sub-module `song_rom`:** synchronous-read ROM indexed by `{song_idx, note_idx}`, initialised from the package array.

## Test plan
Bench settings: `UNIT_CYCLES = 10`, `GAP_CYCLES = 2`, song 0 = {key 0 len 2; key 2 len 1, last}.

- **Basic playback:**
  - `play` at cycle 0 → `key = 0`, `key_on = 1` at cycle 2, for 18 cycles, then 2 low.
  - Next LOAD, then `key = 2`, `key_on` high for 8 cycles.
  - Without `SONG_LOOP_EN`: → IDLE, `busy = 0`.
- **Loop:** with `SONG_LOOP_EN` → after the last note, `key = 0` again; `note_idx = 0`, `busy = 1`.
- **Pause/resume:**
  - `pause` 5 cycles into note 0 → `key_on` low next cycle, `dur_cnt` frozen.
  - `play` 50 cycles later → remaining 13 high cycles of note 0 complete.
- **Priority:** `stop` and `next` in the same cycle during SOUND → IDLE, `song_idx` unchanged, `key_on = 0`.
- **Song wrap:** `next` with `song_idx = NUM_SONGS-1` while playing → `song_idx = 0`, `note_idx = 0`, LOAD.
- **Live override:**
  - `live_on = 1`, `live_key = 9` during GAP → `key = 9`, `key_on = 1` next cycle.
  - Release → sequencer values return; note boundaries are unshifted.
